// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [15:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} pairs; head outputs read zero while empty.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH),
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic               i_push,
  input  logic [15:0]        i_push_pc,
  input  logic [INSTR_W-1:0] i_push_instr,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_valid,
  output logic [15:0]        o_head_pc,
  output logic [INSTR_W-1:0] o_head_instr
);

  fetch_entry_t     r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = i_pop & (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (!i_n_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_n_rst && !i_flush && i_push) begin
      r_mem[r_wr_ptr] <= '{pc: i_push_pc, instr: i_push_instr};
    end
  end

  assign o_count      = r_count;
  assign o_valid      = (r_count != '0);
  assign o_head_pc    = o_valid ? r_mem[r_rd_ptr].pc : '0;
  assign o_head_instr = o_valid ? r_mem[r_rd_ptr].instr : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// instruction buffer, with decoder-driven redirects and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0]  RESET_PC  = 16'h0000,
  parameter int unsigned  BUF_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic               i_pc_override,
  input  logic [15:0]        i_pc_offset,
  input  logic               i_halt,
  output logic               o_imem_req,
  output logic [15:0]        o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [15:0]        o_instr_pc,
  input  logic               i_instr_ready
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [15:0]      r_fetch_pc;
  logic             r_outstanding;
  logic             r_drop_pending;
  logic             r_active;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic             w_grant;
  logic             w_pop;
  logic             w_redirect;
  logic             w_push;
  logic             w_still_out;
  logic [15:0]      w_target;

  assign w_pop       = o_instr_valid & i_instr_ready;
  assign w_redirect  = w_pop & i_pc_override;
  assign w_target    = o_instr_pc + i_pc_offset;
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_outstanding};

  // r_active holds requests off until the first edge after reset release.
  assign o_imem_req  = r_active & ~i_halt & (r_state == FETCH_REQ) & ~r_outstanding &
                       (w_occupancy < (CNT_W + 1)'(BUF_DEPTH));
  assign o_imem_addr = r_fetch_pc;
  assign w_grant     = o_imem_req & i_imem_gnt;

  // Responses with nothing outstanding (e.g. from before reset) are ignored.
  assign w_push      = i_imem_rvalid & r_outstanding & ~r_drop_pending & ~w_redirect;
  assign w_still_out = w_grant | (r_outstanding & ~i_imem_rvalid);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH_REQ: begin
        if (w_grant)                          w_state_nxt = FETCH_WAIT;
        else if (i_halt && !r_outstanding)    w_state_nxt = HALTED;
      end
      FETCH_WAIT: begin
        if (i_imem_rvalid) w_state_nxt = i_halt ? HALTED : FETCH_REQ;
      end
      HALTED: begin
        if (!i_halt) w_state_nxt = FETCH_REQ;
      end
      default: w_state_nxt = FETCH_REQ;
    endcase
    if (w_redirect) w_state_nxt = i_halt ? HALTED : FETCH_REQ;
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_state        <= FETCH_REQ;
      r_fetch_pc     <= RESET_PC;
      r_outstanding  <= 1'b0;
      r_drop_pending <= 1'b0;
      r_active       <= 1'b0;
    end else begin
      r_active      <= 1'b1;
      r_state       <= w_state_nxt;
      r_outstanding <= w_still_out;
      if (w_redirect)       r_fetch_pc <= w_target;
      else if (w_grant)     r_fetch_pc <= r_fetch_pc + 16'd1;
      if (w_redirect)       r_drop_pending <= w_still_out;
      else if (i_imem_rvalid && r_outstanding) r_drop_pending <= 1'b0;
    end
  end

  // fetch_pc has advanced exactly once since the grant of a non-dropped response.
  fetch_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_n_rst     (i_n_rst),
    .i_push      (w_push),
    .i_push_pc   (r_fetch_pc - 16'd1),
    .i_push_instr(i_imem_rdata),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_count     (w_count),
    .o_valid     (o_instr_valid),
    .o_head_pc   (o_instr_pc),
    .o_head_instr(o_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder model plus hand-derived expectations.
module tb_fetch_unit;

  localparam logic [15:0] KEY = 16'hA5A5;

  logic        clk = 1'b0;
  logic        n_rst, pc_override, halt, instr_ready;
  logic [15:0] pc_offset;
  logic        imem_req, imem_gnt, imem_rvalid, instr_valid;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc;

  logic        wr_req, wr_rvalid, wr_valid;
  logic [15:0] wr_addr, wr_rdata, wr_instr, wr_pc;

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 1;

  logic [15:0] gnt_log[$];
  logic [15:0] pop_pc_log[$];
  logic [15:0] pop_in_log[$];
  logic [15:0] wrap_log[$];

  always #5 clk = ~clk;

  assign imem_gnt = imem_req;

  fetch_unit u_dut (
    .i_clk        (clk),
    .i_n_rst      (n_rst),
    .i_pc_override(pc_override),
    .i_pc_offset  (pc_offset),
    .i_halt       (halt),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (imem_gnt),
    .i_imem_rvalid(imem_rvalid),
    .i_imem_rdata (imem_rdata),
    .o_instr_valid(instr_valid),
    .o_instr      (instr),
    .o_instr_pc   (instr_pc),
    .i_instr_ready(instr_ready)
  );

  fetch_unit #(
    .RESET_PC(16'hFFFE)
  ) u_wrap (
    .i_clk        (clk),
    .i_n_rst      (n_rst),
    .i_pc_override(1'b0),
    .i_pc_offset  (16'h0000),
    .i_halt       (1'b0),
    .o_imem_req   (wr_req),
    .o_imem_addr  (wr_addr),
    .i_imem_gnt   (wr_req),
    .i_imem_rvalid(wr_rvalid),
    .i_imem_rdata (wr_rdata),
    .o_instr_valid(wr_valid),
    .o_instr      (wr_instr),
    .o_instr_pc   (wr_pc),
    .i_instr_ready(1'b1)
  );

  // Memory for u_dut: responds 'lat' cycles after each grant with addr ^ KEY.
  initial begin
    logic        pend;
    logic [15:0] paddr;
    int          wc;
    pend = 1'b0; paddr = '0; wc = 0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
        pend = 1'b1; paddr = imem_addr; wc = lat;
      end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        wc--;
        if (wc <= 0) begin
          imem_rvalid = 1'b1; imem_rdata = paddr ^ KEY; pend = 1'b0;
        end
      end
    end
  end

  initial begin
    logic        g;
    logic [15:0] a;
    wr_rvalid = 1'b0; wr_rdata = '0;
    forever begin
      @(negedge clk);
      g = (wr_req === 1'b1); a = wr_addr;
      @(posedge clk); #1;
      wr_rvalid = g; wr_rdata = a;
    end
  end

  always @(negedge clk) begin
    if (imem_req === 1'b1 && imem_gnt === 1'b1) gnt_log.push_back(imem_addr);
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      pop_pc_log.push_back(instr_pc);
      pop_in_log.push_back(instr);
    end
    if (wr_req === 1'b1 && wrap_log.size() < 3) wrap_log.push_back(wr_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? {16'h0000, q[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); pop_pc_log.delete(); pop_in_log.delete();
  endtask

  task automatic wait_valid(input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      sample();
      if (instr_valid === 1'b1) break;
    end
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    n_rst = 1'b0;
    repeat (cycles) tick();
    n_rst = 1'b1;
    clear_logs();
  endtask

  // Consume the head with pc_override for one cycle, then check the flush.
  task automatic redirect(input logic [15:0] off);
    pc_override = 1'b1; instr_ready = 1'b1; pc_offset = off;
    tick();
    pc_override = 1'b0; instr_ready = 1'b0;
    clear_logs();
    sample();
    check_eq("flush", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; halt = 1'b0; pc_override = 1'b0; pc_offset = '0; instr_ready = 1'b1;

    // Reset and sequential fetch; early override with nothing valid is ignored.
    repeat (3) tick();
    sample();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", 32'(instr), 32'd0);
    check_eq("rst_pc", 32'(instr_pc), 32'd0);
    tick();
    n_rst = 1'b1; pc_override = 1'b1; pc_offset = 16'h0100;
    clear_logs();
    sample();
    check_eq("req_early", 32'(imem_req), 32'd0);
    tick(); tick();
    pc_override = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_rvalid === 1'b1) break;
    end
    check_eq("first_rvalid", 32'(imem_rvalid), 32'd1);
    sample();
    check_eq("lat1_valid", 32'(instr_valid), 32'd1);
    check_eq("lat1_pc", 32'(instr_pc), 32'h0000);
    check_eq("lat1_instr", 32'(instr), 32'(KEY));
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_gnt", q_at(gnt_log, i), 32'(i));
      check_eq("seq_pc", q_at(pop_pc_log, i), 32'(i));
      check_eq("seq_instr", q_at(pop_in_log, i), 32'(16'(i) ^ KEY));
    end

    // Backpressure: two entries fill the buffer, then fetch resumes at 2.
    instr_ready = 1'b0; lat = 1;
    do_reset(2);
    repeat (12) tick();
    sample();
    check_eq("bp_ngnt", 32'(gnt_log.size()), 32'd2);
    check_eq("bp_req", 32'(imem_req), 32'd0);
    check_eq("bp_head", 32'(instr_pc), 32'h0000);
    tick();
    instr_ready = 1'b1;
    clear_logs();
    repeat (12) tick();
    check_eq("bp_resume", q_at(gnt_log, 0), 32'h0002);
    for (int i = 0; i < 3; i++) check_eq("bp_pop", q_at(pop_pc_log, i), 32'(i));

    // Redirect 0 -> 0x0010, then 0x0010 + 0xFFF8 -> 0x0008.
    instr_ready = 1'b0;
    do_reset(2);
    wait_valid(20, "rd0");
    tick();
    redirect(16'h0010);
    wait_valid(20, "rd1");
    check_eq("rd1_pc", 32'(instr_pc), 32'h0010);
    check_eq("rd1_gnt", q_at(gnt_log, 0), 32'h0010);
    tick();
    redirect(16'hFFF8);
    wait_valid(20, "rd2");
    check_eq("rd2_pc", 32'(instr_pc), 32'h0008);
    check_eq("rd2_gnt", q_at(gnt_log, 0), 32'h0008);

    // Redirect while a slow response is in flight; the stale word must vanish.
    lat = 3;
    do_reset(2);
    wait_valid(30, "fl0");
    tick();
    redirect(16'h0040);
    wait_valid(40, "fl1");
    check_eq("fl_pc", 32'(instr_pc), 32'h0040);
    check_eq("fl_instr", 32'(instr), 32'(16'h0040 ^ KEY));
    check_eq("fl_gnt", q_at(gnt_log, 0), 32'h0040);

    // Wrap of the redirect target: 0x40 -> 0xFFF0, then 0xFFF0 + 0x20 -> 0x0010.
    lat = 1;
    tick();
    redirect(16'hFFB0);
    wait_valid(20, "wr0");
    check_eq("wr0_pc", 32'(instr_pc), 32'hFFF0);
    tick();
    redirect(16'h0020);
    wait_valid(20, "wr1");
    check_eq("wr1_pc", 32'(instr_pc), 32'h0010);
    check_eq("wr1_gnt", q_at(gnt_log, 0), 32'h0010);
    check_eq("wrap0", q_at(wrap_log, 0), 32'hFFFE);
    check_eq("wrap1", q_at(wrap_log, 1), 32'hFFFF);
    check_eq("wrap2", q_at(wrap_log, 2), 32'h0000);

    // Halt during FETCH_WAIT, drain while halted, resume, then mid-run reset.
    lat = 3;
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      sample();
      if (imem_req === 1'b1 && imem_gnt === 1'b1) break;
    end
    check_eq("halt_gnt", 32'(imem_req & imem_gnt), 32'd1);
    tick();
    halt = 1'b1;
    wait_valid(20, "halt");
    check_eq("halt_pc", 32'(instr_pc), 32'h0000);
    repeat (8) tick();
    sample();
    check_eq("halt_req", 32'(imem_req), 32'd0);
    check_eq("halt_ngnt", 32'(gnt_log.size()), 32'd1);
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    sample();
    check_eq("drain_valid", 32'(instr_valid), 32'd0);
    check_eq("drain_pc", q_at(pop_pc_log, 0), 32'h0000);
    tick();
    halt = 1'b0;
    wait_valid(30, "resume");
    check_eq("resume_pc", 32'(instr_pc), 32'h0001);
    tick();
    n_rst = 1'b0;
    tick();
    sample();
    check_eq("mrst_req", 32'(imem_req), 32'd0);
    check_eq("mrst_valid", 32'(instr_valid), 32'd0);
    check_eq("mrst_instr", 32'(instr), 32'd0);
    check_eq("mrst_pc", 32'(instr_pc), 32'd0);
    tick();
    n_rst = 1'b1;
    clear_logs();
    wait_valid(40, "mrst");
    check_eq("mrst_first_pc", 32'(instr_pc), 32'h0000);
    check_eq("mrst_first_instr", 32'(instr), 32'(KEY));
    check_eq("mrst_gnt", q_at(gnt_log, 0), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
